key_debounce_multi: RTL and testbench

//  Parametrised multi-channel push-button conditioner; successor to the single-key filter.

---
 rtl/key_debounce_multi_pkg.sv | 21 ++
 rtl/key_debounce_ch.sv | 156 +++++++++++++++
 rtl/key_debounce_multi.sv | 40 ++++
 tb/tb_key_debounce_multi.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_multi_pkg.sv
// Shared types and helpers for the multi-key debouncer.
// Channel state encoding and the counter-width function.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Bits needed to hold the largest of the three cycle counts.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, long/repeat timer.
// Ports: clk, rst (sync, high), key_n (raw, 0=pressed), key_level,
// key_press / key_release / key_long (registered 1-cycle pulses).
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  =
    CW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
  localparam logic [CW-1:0] ONE = CW'(1);

  key_state_e    state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          hold_tick;
  logic [CW-1:0] hcnt_inc;

  assign hcnt_inc = hcnt_q + ONE;

  always_comb begin
    state_d   = state_q;
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    rcnt_d    = rcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    hold_tick = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = ONE;
        end else begin
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DEB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          dcnt_d  = '0;
          hcnt_d  = '0;
          rcnt_d  = '0;
        end else begin
          dcnt_d  = dcnt_q + ONE;
        end
      end
      HELD: begin
        hold_tick = 1'b1;
        if (sync2_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          // Bounce back to pressed: long timer is not restarted.
          state_d   = HELD;
          dcnt_d    = '0;
          hold_tick = 1'b1;
        end else if (dcnt_q == DEB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          dcnt_d    = '0;
          hcnt_d    = '0;
          rcnt_d    = '0;
        end else begin
          dcnt_d    = dcnt_q + ONE;
          hold_tick = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // hcnt saturates at LONG_LAST; after that rcnt drives repeats.
    if (hold_tick) begin
      if (hcnt_q != LONG_LAST) begin
        hcnt_d = hcnt_inc;
        if (hcnt_inc == LONG_LAST) long_d = 1'b1;
      end else if (REPEAT_CYC > 0) begin
        if (rcnt_q == REP_LAST) begin
          rcnt_d = '0;
          long_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      rcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      rcnt_q    <= rcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: one key_debounce_ch per key.
// Ports: clk, rst (sync, high), key_n[N] in; key_level, key_press,
// key_release, key_long [N] and any_press (OR of key_press) out.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              any_press
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

  assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi (N=4, DEB=4, LONG=20, REP=8).
// Vector table for the basic path plus hand sequences for corners.
module tb_key_debounce_multi;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;
  logic       any_press;

  int checks = 0;
  int errors = 0;

  key_debounce_multi #(
    .N_KEYS       (4),
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .REPEAT_CYC   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .any_press   (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [3:0] key_n;
    int         ncyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
    logic       any;
  } vec_t;

  vec_t vecs[12];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string nm, input logic [3:0] got,
                      input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input int i, input logic got,
                      input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s i=%0d got %b exp %b", nm, i, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic wait_press(input int ch, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      step(1);
      n++;
      if (key_press[ch]) break;
    end
  endtask

  int n;

  initial begin
    rst   = 1'b1;
    key_n = 4'hF;

    vecs[0]  = '{1'b1, 4'hF, 2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'hE, 5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 4'hE, 1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1};
    vecs[4]  = '{1'b0, 4'hE, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 4'hC, 3, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 4'hE, 6, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[7]  = '{1'b0, 4'hE, 8, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'hE, 1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 5, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    step(1);
    for (int v = 0; v < 12; v++) begin
      rst   = vecs[v].rst;
      key_n = vecs[v].key_n;
      step(vecs[v].ncyc);
      chk4($sformatf("vec%0d level", v), key_level, vecs[v].lvl);
      chk4($sformatf("vec%0d press", v), key_press, vecs[v].prs);
      chk4($sformatf("vec%0d release", v), key_release, vecs[v].rel);
      chk4($sformatf("vec%0d long", v), key_long, vecs[v].lng);
      chk1($sformatf("vec%0d any", v), v, any_press, vecs[v].any);
    end

    // Long press with repeats on ch2, release mid-repeat window.
    key_n = 4'b1011;
    wait_press(2, 20, n);
    chk_int("t3 press latency", n, 6);
    for (int i = 1; i <= 48; i++) begin
      step(1);
      chk1("t3 long2", i, key_long[2],
           (i == 19 || i == 27 || i == 35 || i == 43));
      chk1("t3 rel2", i, key_release[2], (i == 46));
      chk1("t3 lvl2", i, key_level[2], (i < 46));
      chk4("t3 other long", {key_long[3], 1'b0, key_long[1:0]}, 4'h0);
      if (i == 40) key_n = 4'hF;
    end

    // Bounce on ch3 while held: no release, long timer unaffected.
    key_n = 4'b0111;
    wait_press(3, 20, n);
    chk_int("t4 press latency", n, 6);
    for (int i = 1; i <= 30; i++) begin
      step(1);
      chk1("t4 long3", i, key_long[3], (i == 19));
      chk1("t4 rel3", i, key_release[3], (i == 26));
      chk1("t4 lvl3", i, key_level[3], (i < 26));
      if (i == 10) key_n[3] = 1'b1;
      if (i == 12) key_n[3] = 1'b0;
      if (i == 20) key_n[3] = 1'b1;
    end

    // All keys together.
    key_n = 4'h0;
    step(5);
    chk4("t5 press early", key_press, 4'h0);
    step(1);
    chk4("t5 press all", key_press, 4'hF);
    chk4("t5 level all", key_level, 4'hF);
    chk1("t5 any", 0, any_press, 1'b1);
    step(1);
    chk4("t5 press after", key_press, 4'h0);
    chk1("t5 any after", 1, any_press, 1'b0);
    key_n = 4'hF;
    step(5);
    chk4("t5 rel early", key_release, 4'h0);
    step(1);
    chk4("t5 rel all", key_release, 4'hF);
    chk4("t5 level off", key_level, 4'h0);
    step(1);
    chk4("t5 rel after", key_release, 4'h0);

    // Reset while ch0 held, key stays low.
    key_n = 4'hE;
    wait_press(0, 20, n);
    chk_int("t6 press latency", n, 6);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk4("t6 rst level", key_level, 4'h0);
    chk4("t6 rst press", key_press, 4'h0);
    chk4("t6 rst release", key_release, 4'h0);
    chk4("t6 rst long", key_long, 4'h0);
    chk1("t6 rst any", 0, any_press, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step(1);
      chk1("t6 press0", i, key_press[0], (i == 6));
      chk1("t6 lvl0", i, key_level[0], (i >= 6));
      chk1("t6 rel0", i, key_release[0], 1'b0);
    end
    key_n = 4'hF;
    step(8);
    chk4("t6 final level", key_level, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
